// File: rtl/im_pkg.sv
// Shared types and helpers for the instruction memory: FSM states, the default
// NOP word, and the address legality check used by both the fetch and load ports.
package im_pkg;

  typedef enum logic {
    IM_CLEAR = 1'b0,
    IM_RUN   = 1'b1
  } im_state_e;

  localparam logic [31:0] IM_NOP_DEFAULT = 32'h0000_0000;

  // Legal iff word-aligned and no bits set above the index field; addresses are zero-extended to 64 bits
  function automatic logic im_idx_ok(input logic [63:0] a, input int unsigned idx_w);
    logic [63:0] hi;
    hi = a >> (idx_w + 2);
    return (a[1:0] == 2'b00) && (hi == 64'd0);
  endfunction

endpackage

// File: rtl/im_ram.sv
// DEPTH x DATA_W storage with one write port and two independent synchronous
// read-first read ports; each read register only updates when its enable is high.
module im_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads sample the pre-edge array contents, so a same-cycle write is seen one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (re_a) rdata_a <= mem[raddr_a];
      if (re_b) rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/im_sync.sv
// Instruction memory for the fetch stage: registered fetch port with stall hold and
// fault flag, load/debug port, and a post-reset sweep that fills memory with NOP_WORD.
module im_sync
  import im_pkg::*;
#(
  parameter int              DATA_W         = 32,
  parameter int              DEPTH          = 128,
  parameter int              ADDR_W         = 32,
  parameter logic [DATA_W-1:0] NOP_WORD     = DATA_W'(IM_NOP_DEFAULT),
  parameter int              CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              fetch_req,
  input  logic              stall,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              fault,
  input  logic [ADDR_W-1:0] im_add,
  input  logic [DATA_W-1:0] im_data,
  input  logic              im_en,
  input  logic              im_rd_wr,
  output logic [DATA_W-1:0] im_rdata,
  output logic              im_rvalid,
  output logic              ready
);

  localparam int unsigned    IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W:0] CLR_LAST = (IDX_W + 1)'(DEPTH - 1);

  im_state_e         state_q, state_d;
  logic [IDX_W:0]    clr_idx_q, clr_idx_d;
  logic              running, clearing;
  logic              fetch_ok, ld_ok;
  logic [IDX_W-1:0]  fetch_idx, ld_idx;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              fetch_rd, ld_rd;
  logic [DATA_W-1:0] ram_q_a, ram_q_b;
  logic              fetch_nop_q, ld_nop_q;

  assign running   = (state_q == IM_RUN);
  assign clearing  = (state_q == IM_CLEAR);
  assign ready     = running;
  assign fetch_ok  = im_idx_ok(64'(addr), IDX_W);
  assign ld_ok     = im_idx_ok(64'(im_add), IDX_W);
  assign fetch_idx = addr[IDX_W+1:2];
  assign ld_idx    = im_add[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? IM_CLEAR : IM_RUN;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Sweep advances one word per cycle; the wide counter keeps the terminal compare from wrapping
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ram_we    = 1'b0;
    ram_waddr = ld_idx;
    ram_wdata = im_data;
    fetch_rd  = 1'b0;
    ld_rd     = 1'b0;
    case (state_q)
      IM_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx_q[IDX_W-1:0];
        ram_wdata = NOP_WORD;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == CLR_LAST) state_d = IM_RUN;
      end
      IM_RUN: begin
        ram_we   = im_en && im_rd_wr && ld_ok;
        fetch_rd = !stall && fetch_req && fetch_ok;
        ld_rd    = im_en && !im_rd_wr && ld_ok;
      end
      default: state_d = IM_CLEAR;
    endcase
  end

  im_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re_a    (fetch_rd),
    .raddr_a (fetch_idx),
    .rdata_a (ram_q_a),
    .re_b    (ld_rd),
    .raddr_b (ld_idx),
    .rdata_b (ram_q_b)
  );

  // fetch_nop_q remembers whether the last accepted fetch faulted, so data keeps NOP until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid  <= 1'b0;
      fault       <= 1'b0;
      fetch_nop_q <= 1'b0;
    end else if (!stall) begin
      if (running && fetch_req) begin
        data_valid  <= 1'b1;
        fault       <= !fetch_ok;
        fetch_nop_q <= !fetch_ok;
      end else begin
        data_valid <= 1'b0;
        fault      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_rvalid <= 1'b0;
      ld_nop_q  <= 1'b0;
    end else begin
      im_rvalid <= running && im_en && !im_rd_wr;
      if (running && im_en && !im_rd_wr) ld_nop_q <= !ld_ok;
    end
  end

  assign data     = fetch_nop_q ? NOP_WORD : ram_q_a;
  assign im_rdata = ld_nop_q ? NOP_WORD : ram_q_b;

endmodule

// File: tb/tb_im_sync.sv
// Self-checking bench for im_sync: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a word-array reference model.
module tb_im_sync;

  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        fetch_req;
  logic        stall;
  logic [31:0] data;
  logic        data_valid;
  logic        fault;
  logic [31:0] im_add;
  logic [31:0] im_data;
  logic        im_en;
  logic        im_rd_wr;
  logic [31:0] im_rdata;
  logic        im_rvalid;
  logic        ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  im_sync #(
    .DATA_W         (32),
    .DEPTH          (DEPTH),
    .ADDR_W         (32),
    .NOP_WORD       (NOP),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .fetch_req  (fetch_req),
    .stall      (stall),
    .data       (data),
    .data_valid (data_valid),
    .fault      (fault),
    .im_add     (im_add),
    .im_data    (im_data),
    .im_en      (im_en),
    .im_rd_wr   (im_rd_wr),
    .im_rdata   (im_rdata),
    .im_rvalid  (im_rvalid),
    .ready      (ready)
  );

  // Reference model: a plain word array plus the expected register values after each edge
  logic [31:0] mm [DEPTH];
  bit          m_on       = 1'b0;
  bit          m_clearing = 1'b0;
  int          m_cnt      = 0;
  logic [31:0] e_data, e_rdata;
  logic        e_dv, e_fault, e_rv;

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH * 4);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_clearing = 1'b1; m_cnt = 0;
      e_data = '0; e_dv = 1'b0; e_fault = 1'b0; e_rdata = '0; e_rv = 1'b0;
    end else if (m_on) begin
      if (!stall) begin
        if (!m_clearing && fetch_req) begin
          e_dv    = 1'b1;
          e_fault = !addr_ok(addr);
          e_data  = addr_ok(addr) ? mm[int'(addr >> 2)] : NOP;
        end else begin
          e_dv = 1'b0; e_fault = 1'b0;
        end
      end
      e_rv = !m_clearing && im_en && !im_rd_wr;
      if (e_rv) e_rdata = addr_ok(im_add) ? mm[int'(im_add >> 2)] : NOP;
      if (!m_clearing && im_en && im_rd_wr && addr_ok(im_add)) mm[int'(im_add >> 2)] = im_data;
      if (m_clearing) begin
        mm[m_cnt] = NOP;
        m_cnt++;
        if (m_cnt == DEPTH) m_clearing = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      checkOutput("m_ready",  32'(ready),      32'(!m_clearing));
      checkOutput("m_data",   data,            e_data);
      checkOutput("m_dvalid", 32'(data_valid), 32'(e_dv));
      checkOutput("m_fault",  32'(fault),      32'(e_fault));
      checkOutput("m_rdata",  im_rdata,        e_rdata);
      checkOutput("m_rvalid", 32'(im_rvalid),  32'(e_rv));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic fr, input logic [31:0] a, input logic st,
                               input logic en, input logic rw, input logic [31:0] ia,
                               input logic [31:0] id);
    fetch_req = fr; addr = a; stall = st;
    im_en = en; im_rd_wr = rw; im_add = ia; im_data = id;
    tick();
  endtask

  task automatic countClear(input string name);
    int n = 0;
    while (!ready && n < 400) begin
      n++;
      checkOutput({name, "_rvalid"}, 32'(im_rvalid), 32'd0);
      fetch_req = 1'b1; addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      im_en = 1'b1; im_rd_wr = 1'b0; im_add = 32'h10;
      tick();
    end
    checkOutput({name, "_cycles"}, 32'(n), 32'd128);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; addr = '0; stall = 1'b0;
    im_add = '0; im_data = '0; im_en = 1'b0; im_rd_wr = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("rst_data",   data,            32'h0);
    checkOutput("rst_dvalid", 32'(data_valid), 32'h0);
    checkOutput("rst_rdata",  im_rdata,        32'h0);
    countClear("clear");

    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
    checkOutput("nop_fetch", data, NOP);

    applyStimulus(0, 0, 0, 1, 1, 32'h10, 32'h8C01_0004);
    applyStimulus(0, 0, 0, 1, 1, 32'h14, 32'h1122_3344);
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
    checkOutput("ld_data",   data,            32'h8C01_0004);
    checkOutput("ld_dvalid", 32'(data_valid), 32'h1);
    checkOutput("ld_fault",  32'(fault),      32'h0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h14, 1, 0, 0, 0, 0);
      checkOutput("stall_data",   data,            32'h8C01_0004);
      checkOutput("stall_dvalid", 32'(data_valid), 32'h1);
      checkOutput("stall_fault",  32'(fault),      32'h0);
    end
    applyStimulus(1, 32'h14, 0, 0, 0, 0, 0);
    checkOutput("unstall_data", data, 32'h1122_3344);

    applyStimulus(1, 32'h12, 0, 0, 0, 0, 0);
    checkOutput("mis_fault", 32'(fault), 32'h1);
    checkOutput("mis_data",  data,       NOP);
    applyStimulus(1, 32'h200, 0, 0, 0, 0, 0);
    checkOutput("oor_fault", 32'(fault), 32'h1);
    applyStimulus(0, 0, 0, 1, 1, 32'h200, 32'hBAD0_BAD0);
    applyStimulus(1, 32'h0, 0, 1, 0, 32'h0, 0);
    checkOutput("oor_wr_rdata", im_rdata, NOP);
    checkOutput("oor_wr_data",  data,     NOP);
    applyStimulus(0, 0, 0, 1, 0, 32'h200, 0);
    checkOutput("oor_rd_rdata",  im_rdata,        NOP);
    checkOutput("oor_rd_rvalid", 32'(im_rvalid),  32'h1);

    applyStimulus(1, 32'h20, 0, 1, 1, 32'h20, 32'hDEAD_BEEF);
    checkOutput("coll_old", data, NOP);
    applyStimulus(1, 32'h20, 0, 0, 0, 0, 0);
    checkOutput("coll_new", data, 32'hDEAD_BEEF);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] fa, la;
      fa = ($urandom % 5 != 0) ? (32'($urandom_range(0, DEPTH - 1)) << 2) : 32'($urandom_range(0, 1023));
      la = ($urandom % 5 != 0) ? (32'($urandom_range(0, DEPTH - 1)) << 2) : 32'($urandom_range(0, 1023));
      applyStimulus(1'($urandom % 4 != 0), fa, 1'($urandom % 5 == 0),
                    1'($urandom % 2), 1'($urandom % 2), la, $urandom);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      checkOutput("mid_rvalid", 32'(im_rvalid), 32'd0);
      applyStimulus(1, 32'h10, 0, 1, 0, 32'h10, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    countClear("midclr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
